hdp_receiver: RTL and testbench

Receive-side model of the HDP panel data interface driven by `FPGA_LCD_top`, used as the panel end in the system bench and as an on-FPGA loopback checker.
- Samples the 32-bit packet stream with `valid`/`update` framing.
- Enforces line/frame geometry: 40 data + 4 blank packets per line, 1280 lines, 24-cycle back porch.
- Re-emits accepted packets with line/frame position, a per-frame XOR checksum and sticky protocol-error reporting.

---
 rtl/hdp_pkg.sv | 35 +++
 rtl/hdp_geometry_counter.sv | 85 ++++++++
 rtl/hdp_receiver.sv | 184 ++++++++++++++++++
 tb/tb_hdp_receiver.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdp_pkg.sv
// Shared definitions for the HDP panel receive path.
// Contents: default frame geometry, the framing FSM state encoding,
// protocol error codes and a counter-width helper.
package hdp_pkg;

    localparam int HDP_PACKETS_PER_LINE = 40;
    localparam int HDP_BLANK_PER_LINE   = 4;
    localparam int HDP_LINES            = 1280;
    localparam int HDP_BACK_PORCH       = 24;

    localparam int DATA_W       = 32;
    localparam int LINE_W       = 11;
    localparam int FRAME_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LINE_DATA  = 2'd1,
        ST_LINE_BLANK = 2'd2,
        ST_BACK_PORCH = 2'd3
    } hdpState_t;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_SHORT_LINE   = 3'd1,
        ERR_LONG_LINE    = 3'd2,
        ERR_PORCH_DATA   = 3'd3,
        ERR_EARLY_UPDATE = 3'd4
    } hdpError_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdp_geometry_counter.sv
// Nested position counters for one HDP frame: packet within line, blank
// cycle within line, line within frame and back-porch cycle.
// Ports:
//   clock, nReset   clock and synchronous active-low reset
//   clkEn           cycle qualifier; counters hold when low
//   clear           return every counter to 0 (frame end or error)
//   start           first packet of a frame accepted: pkt=1, others 0
//   stepPkt         advance packet counter (wraps after the last packet)
//   stepBlank       advance blank counter; bumps line at end of blank
//   stepPorch       advance porch counter
//   pkt, line       current packet and line index
//   pktLast, blankLast, lineLast, porchLast   terminal-count flags
module hdp_geometry_counter
    import hdp_pkg::*;
#(
    parameter int PACKETS_PER_LINE = HDP_PACKETS_PER_LINE,
    parameter int BLANK_PER_LINE   = HDP_BLANK_PER_LINE,
    parameter int LINES            = HDP_LINES,
    parameter int BACK_PORCH       = HDP_BACK_PORCH,
    parameter int PKT_W            = cntWidth(HDP_PACKETS_PER_LINE)
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              clkEn,
    input  logic              clear,
    input  logic              start,
    input  logic              stepPkt,
    input  logic              stepBlank,
    input  logic              stepPorch,
    output logic [PKT_W-1:0]  pkt,
    output logic [LINE_W-1:0] line,
    output logic              pktLast,
    output logic              blankLast,
    output logic              lineLast,
    output logic              porchLast
);

    localparam int BLANK_W = cntWidth(BLANK_PER_LINE);
    localparam int PORCH_W = cntWidth(BACK_PORCH);

    logic [BLANK_W-1:0] blank;
    logic [PORCH_W-1:0] porch;

    assign pktLast   = (pkt   == PKT_W'(PACKETS_PER_LINE - 1));
    assign blankLast = (blank == BLANK_W'(BLANK_PER_LINE - 1));
    assign lineLast  = (line  == LINE_W'(LINES - 1));
    assign porchLast = (porch == PORCH_W'(BACK_PORCH - 1));

    always_ff @(posedge clock) begin
        if (!nReset) begin
            pkt   <= '0;
            blank <= '0;
            line  <= '0;
            porch <= '0;
        end else if (clkEn) begin
            if (clear) begin
                pkt   <= '0;
                blank <= '0;
                line  <= '0;
                porch <= '0;
            end else if (start) begin
                // Packet 0 is consumed by the start cycle itself.
                pkt   <= PKT_W'(1);
                blank <= '0;
                line  <= '0;
                porch <= '0;
            end else begin
                if (stepPkt) begin
                    pkt <= pktLast ? '0 : pkt + PKT_W'(1);
                end
                if (stepBlank) begin
                    blank <= blankLast ? '0 : blank + BLANK_W'(1);
                    // The last line keeps its index through the porch.
                    if (blankLast && !lineLast) begin
                        line <= line + LINE_W'(1);
                    end
                end
                if (stepPorch) begin
                    porch <= porchLast ? '0 : porch + PORCH_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hdp_receiver.sv
// Receive end of the HDP panel interface. Checks line/frame geometry of
// the valid/update framed packet stream, re-emits accepted packets with
// their line position, accumulates a per-frame XOR checksum and reports
// the first protocol error since the last clear.
// Ports:
//   i_clock, i_nReset        clock and synchronous active-low reset
//   i_clkEn                  cycle qualifier; state holds when low
//   i_lcdData, i_valid       packet stream
//   i_update                 frame marker, rising edge starts a frame
//   i_clearError             clears the sticky error
//   o_pixelData/o_pixelValid accepted packet, one cycle after sampling
//   o_lineStart, o_lineCount first-packet-of-line flag and line index
//   o_frameDone              one-cycle pulse at the end of a clean frame
//   o_frameChecksum          XOR of every packet of the last clean frame
//   o_frameCount             clean frames completed (wrapping)
//   o_error, o_errorCode     sticky error flag and first error code
module hdp_receiver
    import hdp_pkg::*;
#(
    parameter int PACKETS_PER_LINE = HDP_PACKETS_PER_LINE,
    parameter int BLANK_PER_LINE   = HDP_BLANK_PER_LINE,
    parameter int LINES            = HDP_LINES,
    parameter int BACK_PORCH       = HDP_BACK_PORCH
) (
    input  logic                   i_clock,
    input  logic                   i_nReset,
    input  logic                   i_clkEn,
    input  logic [DATA_W-1:0]      i_lcdData,
    input  logic                   i_valid,
    input  logic                   i_update,
    input  logic                   i_clearError,
    output logic [DATA_W-1:0]      o_pixelData,
    output logic                   o_pixelValid,
    output logic                   o_lineStart,
    output logic [LINE_W-1:0]      o_lineCount,
    output logic                   o_frameDone,
    output logic [DATA_W-1:0]      o_frameChecksum,
    output logic [FRAME_CNT_W-1:0] o_frameCount,
    output logic                   o_error,
    output logic [2:0]             o_errorCode
);

    localparam int PKT_W = cntWidth(PACKETS_PER_LINE);

    hdpState_t         state;
    logic              updateD;
    logic [DATA_W-1:0] checksum;

    logic [PKT_W-1:0]  pkt;
    logic [LINE_W-1:0] line;
    logic              pktLast;
    logic              blankLast;
    logic              lineLast;
    logic              porchLast;

    logic              updateRise;
    hdpError_t         errCode;
    logic              errHit;
    logic              frameStart;
    logic              accept;
    logic              frameEnd;

    assign updateRise = i_update && !updateD;

    // Line/porch violations first, then an early frame marker overrides
    // them because it explains why the geometry went wrong.
    always_comb begin
        errCode = ERR_NONE;
        case (state)
            ST_LINE_DATA:  if (!i_valid) errCode = ERR_SHORT_LINE;
            ST_LINE_BLANK: if (i_valid)  errCode = ERR_LONG_LINE;
            ST_BACK_PORCH: if (i_valid)  errCode = ERR_PORCH_DATA;
            default:       errCode = ERR_NONE;
        endcase
        if ((state != ST_IDLE) && updateRise) begin
            errCode = ERR_EARLY_UPDATE;
        end
    end

    assign errHit     = (errCode != ERR_NONE);
    assign frameStart = (state == ST_IDLE) && i_valid && updateRise;
    assign accept     = frameStart || ((state == ST_LINE_DATA) && !errHit);
    assign frameEnd   = (state == ST_BACK_PORCH) && porchLast && !errHit;

    hdp_geometry_counter #(
        .PACKETS_PER_LINE (PACKETS_PER_LINE),
        .BLANK_PER_LINE   (BLANK_PER_LINE),
        .LINES            (LINES),
        .BACK_PORCH       (BACK_PORCH),
        .PKT_W            (PKT_W)
    ) geometry (
        .clock     (i_clock),
        .nReset    (i_nReset),
        .clkEn     (i_clkEn),
        .clear     (errHit || frameEnd),
        .start     (frameStart),
        .stepPkt   ((state == ST_LINE_DATA) && !errHit),
        .stepBlank (state == ST_LINE_BLANK),
        .stepPorch (state == ST_BACK_PORCH),
        .pkt       (pkt),
        .line      (line),
        .pktLast   (pktLast),
        .blankLast (blankLast),
        .lineLast  (lineLast),
        .porchLast (porchLast)
    );

    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state           <= ST_IDLE;
            updateD         <= 1'b0;
            checksum        <= '0;
            o_pixelData     <= '0;
            o_pixelValid    <= 1'b0;
            o_lineStart     <= 1'b0;
            o_lineCount     <= '0;
            o_frameDone     <= 1'b0;
            o_frameChecksum <= '0;
            o_frameCount    <= '0;
            o_error         <= 1'b0;
            o_errorCode     <= ERR_NONE;
        end else if (!i_clkEn) begin
            // Strobes must not repeat across a stalled cycle.
            o_pixelValid <= 1'b0;
            o_lineStart  <= 1'b0;
            o_frameDone  <= 1'b0;
        end else begin
            updateD      <= i_update;
            o_pixelValid <= accept;
            // Counters sit at 0 in IDLE, so pkt==0 also covers frameStart.
            o_lineStart  <= accept && (pkt == '0);
            o_frameDone  <= frameEnd;

            if (accept) begin
                o_pixelData <= i_lcdData;
                o_lineCount <= line;
            end

            if (frameStart) begin
                checksum <= i_lcdData;
            end else if (accept) begin
                checksum <= checksum ^ i_lcdData;
            end

            if (frameEnd) begin
                o_frameChecksum <= checksum;
                o_frameCount    <= o_frameCount + FRAME_CNT_W'(1);
            end

            // First error wins, except that a clear in the same cycle
            // makes room for the new one.
            if (errHit) begin
                o_error <= 1'b1;
                if (!o_error || i_clearError) begin
                    o_errorCode <= errCode;
                end
            end else if (i_clearError) begin
                o_error     <= 1'b0;
                o_errorCode <= ERR_NONE;
            end

            if (errHit) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frameStart) state <= ST_LINE_DATA;
                    end
                    ST_LINE_DATA: begin
                        if (pktLast) state <= ST_LINE_BLANK;
                    end
                    ST_LINE_BLANK: begin
                        if (blankLast) state <= lineLast ? ST_BACK_PORCH : ST_LINE_DATA;
                    end
                    ST_BACK_PORCH: begin
                        if (porchLast) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdp_receiver.sv
// Bench for hdp_receiver with a reduced frame geometry. Stimulus tasks push
// expected packets and frame results into queues; a monitor on the falling
// edge pops and compares whenever the receiver presents an output.
module tb_hdp_receiver;

    localparam int P  = 24;
    localparam int B  = 4;
    localparam int L  = 160;
    localparam int BP = 24;

    logic        clock = 1'b0;
    logic        nReset, clkEn, valid, update, clearError;
    logic [31:0] lcdData;
    logic [31:0] pixelData;
    logic        pixelValid, lineStart, frameDone, error;
    logic [10:0] lineCount;
    logic [31:0] frameChecksum;
    logic [15:0] frameCount;
    logic [2:0]  errorCode;

    always #5 clock = ~clock;

    hdp_receiver #(
        .PACKETS_PER_LINE (P),
        .BLANK_PER_LINE   (B),
        .LINES            (L),
        .BACK_PORCH       (BP)
    ) dut (
        .i_clock         (clock),
        .i_nReset        (nReset),
        .i_clkEn         (clkEn),
        .i_lcdData       (lcdData),
        .i_valid         (valid),
        .i_update        (update),
        .i_clearError    (clearError),
        .o_pixelData     (pixelData),
        .o_pixelValid    (pixelValid),
        .o_lineStart     (lineStart),
        .o_lineCount     (lineCount),
        .o_frameDone     (frameDone),
        .o_frameChecksum (frameChecksum),
        .o_frameCount    (frameCount),
        .o_error         (error),
        .o_errorCode     (errorCode)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        ls;
        logic [10:0] line;
    } pix_t;

    typedef struct packed {
        logic [31:0] cs;
        logic [15:0] count;
    } frm_t;

    pix_t expPix[$];
    frm_t expFrm[$];
    pix_t popPix;
    frm_t popFrm;

    int checks = 0;
    int errors = 0;
    int nValid = 0;
    int nLineStart = 0;
    int nDone = 0;
    int expFrames = 0;
    bit toggleEn = 1'b0;
    bit clrAtFault = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard side.
    always @(negedge clock) begin
        if (pixelValid) begin
            nValid++;
            if (lineStart) nLineStart++;
            if (expPix.size() == 0) begin
                check("unexpected pixelValid", 64'(pixelValid), 64'd0);
            end else begin
                popPix = expPix.pop_front();
                check("pixelData", 64'(pixelData), 64'(popPix.data));
                check("lineStart", 64'(lineStart), 64'(popPix.ls));
                check("lineCount", 64'(lineCount), 64'(popPix.line));
            end
        end else if (lineStart) begin
            check("lineStart without valid", 64'(lineStart), 64'd0);
        end
        if (frameDone) begin
            nDone++;
            if (expFrm.size() == 0) begin
                check("unexpected frameDone", 64'(frameDone), 64'd0);
            end else begin
                popFrm = expFrm.pop_front();
                check("frameChecksum", 64'(frameChecksum), 64'(popFrm.cs));
                check("frameCount", 64'(frameCount), 64'(popFrm.count));
            end
        end
    end

    // One qualified cycle, optionally preceded by a disabled cycle carrying
    // inverted junk that must be ignored.
    task automatic qcyc(input logic v, input logic u, input logic [31:0] d);
        if (toggleEn) begin
            clkEn = 1'b0; valid = ~v; update = ~u; lcdData = ~d;
            @(posedge clock); #1;
        end
        clkEn = 1'b1; valid = v; update = u; lcdData = d;
        @(posedge clock); #1;
    endtask

    task automatic faultCyc(input logic v, input logic u, input logic [31:0] d);
        clearError = clrAtFault;
        qcyc(v, u, d);
        clearError = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) qcyc(1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " pixelData"},     64'(pixelData),     64'd0);
        check({tag, " pixelValid"},    64'(pixelValid),    64'd0);
        check({tag, " lineStart"},     64'(lineStart),     64'd0);
        check({tag, " lineCount"},     64'(lineCount),     64'd0);
        check({tag, " frameDone"},     64'(frameDone),     64'd0);
        check({tag, " frameChecksum"}, 64'(frameChecksum), 64'd0);
        check({tag, " frameCount"},    64'(frameCount),    64'd0);
        check({tag, " error"},         64'(error),         64'd0);
        check({tag, " errorCode"},     64'(errorCode),     64'd0);
    endtask

    task automatic doReset();
        nReset = 1'b0; clkEn = 1'b1; valid = 1'b0; update = 1'b0;
        clearError = 1'b0; lcdData = 32'h0;
        @(posedge clock); #1;
        checkAllZero("reset");
        nReset = 1'b1;
        expFrames = 0;
    endtask

    task automatic pulseClear();
        clearError = 1'b1;
        qcyc(1'b0, 1'b0, 32'h0);
        clearError = 1'b0;
        check("error after clear", 64'(error), 64'd0);
        check("code after clear", 64'(errorCode), 64'd0);
    endtask

    // kind: 0 clean, 1 short line, 2 long line, 3 porch data,
    // 4 early update in blank, 5 early update together with short line,
    // 6 reset during a data packet. Stops the frame at the fault.
    task automatic runFrame(input int kind, input int fLine, input int fIdx, input logic [31:0] seed);
        logic [31:0] cs;
        logic [31:0] d;
        int k;
        bit stop;
        cs = 32'h0; k = 0; stop = 1'b0;
        for (int ln = 0; ln < L && !stop; ln++) begin
            for (int p = 0; p < P && !stop; p++) begin
                d = seed + 32'(k);
                if ((kind == 1 || kind == 5) && ln == fLine && p == fIdx) begin
                    faultCyc(1'b0, kind == 5, d);
                    stop = 1'b1;
                end else if (kind == 6 && ln == fLine && p == fIdx) begin
                    nReset = 1'b0;
                    qcyc(1'b1, 1'b0, d);
                    nReset = 1'b1;
                    stop = 1'b1;
                end else begin
                    qcyc(1'b1, (ln == 0 && p == 0), d);
                    expPix.push_back('{data: d, ls: (p == 0), line: 11'(ln)});
                    cs = cs ^ d;
                    k++;
                end
            end
            for (int b = 0; b < B && !stop; b++) begin
                if (kind == 2 && ln == fLine && b == fIdx) begin
                    faultCyc(1'b1, 1'b0, $urandom);
                    stop = 1'b1;
                end else if (kind == 4 && ln == fLine && b == fIdx) begin
                    faultCyc(1'b0, 1'b1, $urandom);
                    stop = 1'b1;
                end else begin
                    qcyc(1'b0, 1'b0, $urandom);
                end
            end
        end
        for (int pc = 0; pc < BP && !stop; pc++) begin
            if (kind == 3 && pc == fIdx) begin
                faultCyc(1'b1, 1'b0, $urandom);
                stop = 1'b1;
            end else begin
                qcyc(1'b0, 1'b0, $urandom);
            end
        end
        if (!stop) begin
            expFrames++;
            expFrm.push_back('{cs: cs, count: 16'(expFrames)});
        end
    endtask

    task automatic clearCounts();
        nValid = 0; nLineStart = 0; nDone = 0;
    endtask

    task automatic checkErr(input string name, input logic [2:0] code);
        check({name, " error"}, 64'(error), 64'd1);
        check({name, " errorCode"}, 64'(errorCode), 64'(code));
    endtask

    initial begin
        nReset = 1'b0; clkEn = 1'b0; valid = 1'b0; update = 1'b0;
        clearError = 1'b0; lcdData = 32'h0;
        doReset();

        // Nominal frame: data 0..3839, XOR of 0..4n-1 is 0.
        clearCounts();
        runFrame(0, 0, 0, 32'h0);
        idle(4);
        check("nominal pixelValid pulses", 64'(nValid), 64'(P * L));
        check("nominal lineStart pulses", 64'(nLineStart), 64'(L));
        check("nominal frameDone pulses", 64'(nDone), 64'd1);
        check("nominal frameCount", 64'(frameCount), 64'd1);
        check("nominal frameChecksum", 64'(frameChecksum), 64'd0);
        check("nominal error", 64'(error), 64'd0);
        check("nominal queue drained", 64'(expPix.size()), 64'd0);

        // Same frame with the clock enable toggling every other cycle.
        doReset();
        clearCounts();
        toggleEn = 1'b1;
        runFrame(0, 0, 0, 32'h0);
        idle(4);
        toggleEn = 1'b0;
        check("clkEn pixelValid pulses", 64'(nValid), 64'(P * L));
        check("clkEn lineStart pulses", 64'(nLineStart), 64'(L));
        check("clkEn frameDone pulses", 64'(nDone), 64'd1);
        check("clkEn frameCount", 64'(frameCount), 64'd1);
        check("clkEn frameChecksum", 64'(frameChecksum), 64'd0);
        check("clkEn error", 64'(error), 64'd0);

        // Error cases; frameCount must stay at 1 throughout.
        clearCounts();
        runFrame(1, 5, 20, 32'h1357_9BDF);
        checkErr("short line", 3'd1);
        idle(4);
        check("short line frameCount", 64'(frameCount), 64'd1);
        pulseClear();

        runFrame(2, 0, 2, 32'h2468_ACE1);
        checkErr("long line", 3'd2);
        idle(3);
        pulseClear();

        runFrame(4, 100, 1, 32'h0BAD_F00D);
        checkErr("early update", 3'd4);
        idle(3);
        pulseClear();

        runFrame(5, 3, 7, 32'h5555_0001);
        checkErr("early update with short line", 3'd4);
        idle(3);
        pulseClear();
        check("error frames frameDone pulses", 64'(nDone), 64'd0);
        check("error frames frameCount", 64'(frameCount), 64'd1);
        check("error frames queue drained", 64'(expPix.size()), 64'd0);

        // Porch error, sticky code, clear racing a new error, recovery.
        doReset();
        runFrame(3, 0, 10, 32'hC0DE_0003);
        checkErr("porch data", 3'd3);
        idle(3);
        runFrame(1, 0, 5, 32'h1111_2222);
        checkErr("second error keeps first", 3'd3);
        idle(3);
        clrAtFault = 1'b1;
        runFrame(2, 1, 0, 32'h3333_4444);
        clrAtFault = 1'b0;
        checkErr("clear with new error", 3'd2);
        idle(3);
        pulseClear();
        clearCounts();
        runFrame(0, 0, 0, 32'hA5A5_0003);
        idle(4);
        check("recovery frameDone pulses", 64'(nDone), 64'd1);
        check("recovery frameCount", 64'(frameCount), 64'd1);
        check("recovery error", 64'(error), 64'd0);

        // Reset in the middle of the frame, then a clean frame.
        runFrame(6, 80, 3, 32'h7777_0005);
        checkAllZero("mid-frame reset");
        expFrames = 0;
        check("mid-frame reset queue drained", 64'(expPix.size()), 64'd0);
        idle(2);
        clearCounts();
        runFrame(0, 0, 0, 32'hFEDC_BA99);
        idle(4);
        check("post-reset frameDone pulses", 64'(nDone), 64'd1);
        check("post-reset frameCount", 64'(frameCount), 64'd1);
        check("post-reset error", 64'(error), 64'd0);
        check("final frame queue drained", 64'(expFrm.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
